m_w_stage: RTL and testbench

M_W_STAGE -- requirements
Module: m_w_stage

---
 rtl/m_w_stage_pkg.sv | 72 +++++++
 rtl/m_w_stage_if.sv | 22 ++
 rtl/m_w_stage_dm_ext.sv | 43 ++++
 rtl/m_w_stage.sv | 177 +++++++++++++++++
 tb/tb_m_w_stage.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/m_w_stage_pkg.sv
// Shared definitions for the M/W stage: opcodes, FSM and retire encodings,
// default bus timeout, and per-opcode helpers for alignment, byte enables
// and store-lane replication.
package m_w_stage_pkg;

  localparam int unsigned XLEN            = 32;
  localparam int unsigned BE_W            = 4;
  localparam int unsigned TIMEOUT_DEFAULT = 255;

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SB  = 6'b101000;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // What the M/W register does at the coming edge.
  typedef enum logic [2:0] {
    RET_NONE     = 3'd0,
    RET_PASS     = 3'd1,
    RET_ADDR_ERR = 3'd2,
    RET_BUS_OK   = 3'd3,
    RET_BUS_ERR  = 3'd4
  } ret_e;

  function automatic logic op_is_mem(input logic [5:0] op);
    case (op)
      OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU, OP_SW, OP_SH, OP_SB: op_is_mem = 1'b1;
      default: op_is_mem = 1'b0;
    endcase
  endfunction

  function automatic logic op_is_store(input logic [5:0] op);
    case (op)
      OP_SW, OP_SH, OP_SB: op_is_store = 1'b1;
      default: op_is_store = 1'b0;
    endcase
  endfunction

  function automatic logic op_misaligned(input logic [5:0] op, input logic [1:0] a);
    case (op)
      OP_LW, OP_SW:         op_misaligned = (a != 2'b00);
      OP_LH, OP_LHU, OP_SH: op_misaligned = a[0];
      default:              op_misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] op_be(input logic [5:0] op, input logic [1:0] a);
    case (op)
      OP_LW, OP_SW:                 op_be = 4'b1111;
      OP_LH, OP_LHU, OP_SH:         op_be = 4'b0011 << {a[1], 1'b0};
      OP_LB, OP_LBU, OP_SB:         op_be = 4'b0001 << a;
      default:                      op_be = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] op_wdata(input logic [5:0] op, input logic [31:0] d);
    case (op)
      OP_SB:   op_wdata = {4{d[7:0]}};
      OP_SH:   op_wdata = {2{d[15:0]}};
      default: op_wdata = d;
    endcase
  endfunction

endpackage

// File: rtl/m_w_stage_if.sv
// Data-bus bundle between the M/W stage (master) and the memory (slave).
interface m_w_stage_if;
  import m_w_stage_pkg::*;

  logic              bus_req;
  logic              bus_we;
  logic [XLEN-1:0]   bus_addr;
  logic [BE_W-1:0]   bus_be;
  logic [XLEN-1:0]   bus_wdata;
  logic [XLEN-1:0]   bus_rdata;
  logic              bus_ack;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/m_w_stage_dm_ext.sv
// Load data extraction: picks the byte/half lane addressed by addr[1:0]
// and sign- or zero-extends it according to the load opcode.
module dm_ext
  import m_w_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [5:0]  opcode,
  output logic [31:0] data
);

  logic [7:0]  byte_lane_s;
  logic [15:0] half_lane_s;

  // Lane selection from the little-endian read word
  always_comb begin
    case (addr)
      2'd0:    byte_lane_s = rdata[7:0];
      2'd1:    byte_lane_s = rdata[15:8];
      2'd2:    byte_lane_s = rdata[23:16];
      2'd3:    byte_lane_s = rdata[31:24];
      default: byte_lane_s = rdata[7:0];
    endcase
    if (addr[1]) begin
      half_lane_s = rdata[31:16];
    end else begin
      half_lane_s = rdata[15:0];
    end
  end

  // Sign/zero extension by load width
  always_comb begin
    data = rdata;
    case (opcode)
      OP_LB:   data = {{24{byte_lane_s[7]}}, byte_lane_s};
      OP_LBU:  data = {24'h000000, byte_lane_s};
      OP_LH:   data = {{16{half_lane_s[15]}}, half_lane_s};
      OP_LHU:  data = {16'h0000, half_lane_s};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/m_w_stage.sv
// M/W pipeline stage with a stalling request/ack data-bus master.
// Memory ops are captured on issue, wait for ack (or timeout) in WAIT,
// then retire into the M/W register. Misaligned ops retire immediately
// with addr_err_out; timeouts retire with bus_err_out.
module m_w_stage
  import m_w_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ALU_Out_in,
  input  logic [31:0] Data_to_dm_in,
  input  logic [4:0]  WriteReg_in,
  input  logic [31:0] Instr_in,
  input  logic [31:0] PC4_in,
  output logic        stall,
  m_w_stage_if.master bus,
  output logic [31:0] ALU_Out_out,
  output logic [31:0] DM_Data_out,
  output logic [4:0]  WriteReg_out,
  output logic [31:0] Instr_out,
  output logic [31:0] PC4_out,
  output logic        addr_err_out,
  output logic        bus_err_out
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 32'd1);

  state_e      state_r, state_next_s;
  ret_e        ret_s;
  logic        stall_s, capture_s;
  logic [7:0]  cnt_r;
  logic        timeout_s;
  logic [5:0]  op_s;

  logic [31:0] cap_alu_r, cap_wdata_r, cap_instr_r, cap_pc4_r;
  logic [3:0]  cap_be_r;
  logic        cap_we_r;
  logic [4:0]  cap_wreg_r;
  logic [31:0] ext_data_s;

  assign op_s      = Instr_in[31:26];
  assign timeout_s = (cnt_r == TO_LAST);

  // Hold the pipeline only while reset is released
  assign stall = stall_s & reset;

  assign bus.bus_req   = (state_r == ST_WAIT);
  assign bus.bus_we    = cap_we_r;
  assign bus.bus_addr  = {cap_alu_r[31:2], 2'b00};
  assign bus.bus_be    = cap_be_r;
  assign bus.bus_wdata = cap_wdata_r;

  dm_ext u_dm_ext (
    .rdata  (bus.bus_rdata),
    .addr   (cap_alu_r[1:0]),
    .opcode (cap_instr_r[31:26]),
    .data   (ext_data_s)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next state, stall and retire selection
  always_comb begin
    state_next_s = state_r;
    stall_s      = 1'b0;
    capture_s    = 1'b0;
    ret_s        = RET_NONE;
    case (state_r)
      ST_IDLE: begin
        if (!op_is_mem(op_s)) begin
          ret_s = RET_PASS;
        end else if (op_misaligned(op_s, ALU_Out_in[1:0])) begin
          ret_s = RET_ADDR_ERR;
        end else begin
          stall_s      = 1'b1;
          capture_s    = 1'b1;
          state_next_s = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.bus_ack) begin
          ret_s        = RET_BUS_OK;
          state_next_s = ST_IDLE;
        end else if (timeout_s) begin
          ret_s        = RET_BUS_ERR;
          state_next_s = ST_IDLE;
        end else begin
          stall_s = 1'b1;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Timeout counter: cleared on issue, counts WAIT cycles without ack
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_r <= 8'd0;
    end else if (capture_s) begin
      cnt_r <= 8'd0;
    end else if ((state_r == ST_WAIT) && !bus.bus_ack) begin
      cnt_r <= cnt_r + 8'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Capture of the issued access and its E/M fields
  always_ff @(posedge clk) begin
    if (!reset) begin
      cap_alu_r   <= 32'd0;
      cap_wdata_r <= 32'd0;
      cap_instr_r <= 32'd0;
      cap_pc4_r   <= 32'd0;
      cap_be_r    <= 4'd0;
      cap_we_r    <= 1'b0;
      cap_wreg_r  <= 5'd0;
    end else if (capture_s) begin
      cap_alu_r   <= ALU_Out_in;
      cap_wdata_r <= op_wdata(op_s, Data_to_dm_in);
      cap_instr_r <= Instr_in;
      cap_pc4_r   <= PC4_in;
      cap_be_r    <= op_be(op_s, ALU_Out_in[1:0]);
      cap_we_r    <= op_is_store(op_s);
      cap_wreg_r  <= WriteReg_in;
    end
  end

  // M/W register load according to the retire kind
  always_ff @(posedge clk) begin
    if (!reset) begin
      ALU_Out_out  <= 32'd0;
      DM_Data_out  <= 32'd0;
      WriteReg_out <= 5'd0;
      Instr_out    <= 32'd0;
      PC4_out      <= 32'd0;
      addr_err_out <= 1'b0;
      bus_err_out  <= 1'b0;
    end else begin
      case (ret_s)
        RET_PASS, RET_ADDR_ERR: begin
          ALU_Out_out  <= ALU_Out_in;
          DM_Data_out  <= 32'd0;
          WriteReg_out <= (ret_s == RET_PASS) ? WriteReg_in : 5'd0;
          Instr_out    <= Instr_in;
          PC4_out      <= PC4_in;
          addr_err_out <= (ret_s == RET_ADDR_ERR);
          bus_err_out  <= 1'b0;
        end
        RET_BUS_OK, RET_BUS_ERR: begin
          ALU_Out_out  <= cap_alu_r;
          DM_Data_out  <= ((ret_s == RET_BUS_ERR) || cap_we_r) ? 32'd0 : ext_data_s;
          WriteReg_out <= (ret_s == RET_BUS_ERR) ? 5'd0 : cap_wreg_r;
          Instr_out    <= cap_instr_r;
          PC4_out      <= cap_pc4_r;
          addr_err_out <= 1'b0;
          bus_err_out  <= (ret_s == RET_BUS_ERR);
        end
        default: begin
          ALU_Out_out  <= ALU_Out_out;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_m_w_stage.sv
// Directed bench for m_w_stage (TIMEOUT=4): pass-through, loads with
// extension, stores with lane replication, misalignment, timeout,
// ack/timeout race, reset during WAIT and stray acks.
module tb_m_w_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] alu_in, data_in, instr_in, pc4_in;
  logic [4:0]  wreg_in;
  logic        stall;
  logic [31:0] alu_out, dm_out, instr_out, pc4_out;
  logic [4:0]  wreg_out;
  logic        aerr_out, berr_out;
  int          n_cmp = 0;
  int          n_err = 0;

  m_w_stage_if bus_if ();

  m_w_stage #(.TIMEOUT(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .ALU_Out_in    (alu_in),
    .Data_to_dm_in (data_in),
    .WriteReg_in   (wreg_in),
    .Instr_in      (instr_in),
    .PC4_in        (pc4_in),
    .stall         (stall),
    .bus           (bus_if.master),
    .ALU_Out_out   (alu_out),
    .DM_Data_out   (dm_out),
    .WriteReg_out  (wreg_out),
    .Instr_out     (instr_out),
    .PC4_out       (pc4_out),
    .addr_err_out  (aerr_out),
    .bus_err_out   (berr_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_mw(input string tag, input logic [31:0] alu, input logic [31:0] dm,
                        input logic [4:0] wr, input logic [31:0] ins, input logic [31:0] pc4,
                        input logic ae, input logic be);
    chk({tag, ".alu"},   alu_out,  alu);
    chk({tag, ".dm"},    dm_out,   dm);
    chk({tag, ".wreg"},  {27'd0, wreg_out}, {27'd0, wr});
    chk({tag, ".instr"}, instr_out, ins);
    chk({tag, ".pc4"},   pc4_out,  pc4);
    chk({tag, ".aerr"},  {31'd0, aerr_out}, {31'd0, ae});
    chk({tag, ".berr"},  {31'd0, berr_out}, {31'd0, be});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [31:0] a, input logic [31:0] d, input logic [4:0] w,
                        input logic [31:0] i, input logic [31:0] p);
    alu_in = a; data_in = d; wreg_in = w; instr_in = i; pc4_in = p;
    #1;
  endtask

  initial begin
    reset = 1'b0;
    bus_if.bus_ack = 1'b0;
    bus_if.bus_rdata = 32'd0;
    alu_in = 32'd0; data_in = 32'd0; wreg_in = 5'd0; instr_in = 32'd0; pc4_in = 32'd0;
    step();
    step();
    chk_mw("reset", 32'd0, 32'd0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("reset.req",   {31'd0, bus_if.bus_req}, 32'd0);
    chk("reset.stall", {31'd0, stall}, 32'd0);
    reset = 1'b1;

    // addu passes through in one cycle
    set_in(32'h0000_1234, 32'h0000_0055, 5'd5, 32'h0000_0821, 32'h0000_0404);
    chk("addu.stall", {31'd0, stall}, 32'd0);
    step();
    chk_mw("addu", 32'h0000_1234, 32'd0, 5'd5, 32'h0000_0821, 32'h0000_0404, 1'b0, 1'b0);

    // lw at 0x10, ack two cycles after req: stall high for 3 cycles
    set_in(32'h0000_0010, 32'h0000_0077, 5'd2, 32'h8C02_0010, 32'h0000_0408);
    chk("lw.stall0", {31'd0, stall}, 32'd1);
    chk("lw.req0",   {31'd0, bus_if.bus_req}, 32'd0);
    step();
    chk("lw.stall1", {31'd0, stall}, 32'd1);
    chk("lw.req1",   {31'd0, bus_if.bus_req}, 32'd1);
    chk("lw.addr",   bus_if.bus_addr, 32'h0000_0010);
    chk("lw.be",     {28'd0, bus_if.bus_be}, 32'h0000_000F);
    chk("lw.we",     {31'd0, bus_if.bus_we}, 32'd0);
    step();
    chk("lw.stall2", {31'd0, stall}, 32'd1);
    step();
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'hDEAD_BEEF;
    #1;
    chk("lw.stall_ack", {31'd0, stall}, 32'd0);
    step();
    bus_if.bus_ack = 1'b0;
    chk_mw("lw", 32'h0000_0010, 32'hDEAD_BEEF, 5'd2, 32'h8C02_0010, 32'h0000_0408, 1'b0, 1'b0);
    chk("lw.req_done", {31'd0, bus_if.bus_req}, 32'd0);

    // lb at 0x13, then lbu back-to-back
    set_in(32'h0000_0013, 32'd0, 5'd3, 32'h8003_0013, 32'h0000_040C);
    step();
    chk("lb.be", {28'd0, bus_if.bus_be}, 32'h0000_0008);
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h8011_2233;
    step();
    bus_if.bus_ack = 1'b0;
    chk_mw("lb", 32'h0000_0013, 32'hFFFF_FF80, 5'd3, 32'h8003_0013, 32'h0000_040C, 1'b0, 1'b0);
    set_in(32'h0000_0013, 32'd0, 5'd4, 32'h9004_0013, 32'h0000_0410);
    chk("lbu.stall_issue", {31'd0, stall}, 32'd1);
    step();
    chk("lbu.req_b2b", {31'd0, bus_if.bus_req}, 32'd1);
    bus_if.bus_ack = 1'b1;
    step();
    bus_if.bus_ack = 1'b0;
    chk_mw("lbu", 32'h0000_0013, 32'h0000_0080, 5'd4, 32'h9004_0013, 32'h0000_0410, 1'b0, 1'b0);

    // lh at 0x02 sign-extends the upper half
    set_in(32'h0000_0002, 32'd0, 5'd7, 32'h8407_0002, 32'h0000_0414);
    step();
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h8001_7FFF;
    step();
    bus_if.bus_ack = 1'b0;
    chk("lh.dm", dm_out, 32'hFFFF_8001);

    // sh at 0x06 replicates the halfword into the upper lanes
    set_in(32'h0000_0006, 32'h0000_ABCD, 5'd0, 32'hA405_0006, 32'h0000_0418);
    step();
    chk("sh.be",    {28'd0, bus_if.bus_be}, 32'h0000_000C);
    chk("sh.wdata", bus_if.bus_wdata, 32'hABCD_ABCD);
    chk("sh.we",    {31'd0, bus_if.bus_we}, 32'd1);
    chk("sh.addr",  bus_if.bus_addr, 32'h0000_0004);
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h1234_5678;
    step();
    bus_if.bus_ack = 1'b0;
    chk_mw("sh", 32'h0000_0006, 32'd0, 5'd0, 32'hA405_0006, 32'h0000_0418, 1'b0, 1'b0);

    // sb at 0x01
    set_in(32'h0000_0001, 32'h0000_00EF, 5'd0, 32'hA000_0001, 32'h0000_041C);
    step();
    chk("sb.be",    {28'd0, bus_if.bus_be}, 32'h0000_0002);
    chk("sb.wdata", bus_if.bus_wdata, 32'hEFEF_EFEF);
    bus_if.bus_ack = 1'b1;
    step();
    bus_if.bus_ack = 1'b0;

    // Misaligned lw at 0x02: no request, no stall, addr_err retire
    set_in(32'h0000_0002, 32'd0, 5'd6, 32'h8C06_0002, 32'h0000_0500);
    chk("mis.stall", {31'd0, stall}, 32'd0);
    chk("mis.req",   {31'd0, bus_if.bus_req}, 32'd0);
    step();
    chk_mw("mis_lw", 32'h0000_0002, 32'd0, 5'd0, 32'h8C06_0002, 32'h0000_0500, 1'b1, 1'b0);
    chk("mis.req2", {31'd0, bus_if.bus_req}, 32'd0);
    set_in(32'h0000_0001, 32'd0, 5'd0, 32'hA400_0001, 32'h0000_0504);
    chk("mis_sh.stall", {31'd0, stall}, 32'd0);
    step();
    chk("mis_sh.aerr", {31'd0, aerr_out}, 32'd1);
    set_in(32'h0000_0099, 32'd0, 5'd1, 32'h0000_0821, 32'h0000_0508);
    step();
    chk("clear.aerr", {31'd0, aerr_out}, 32'd0);

    // sw timeout after 4 WAIT cycles
    set_in(32'h0000_0020, 32'h1122_3344, 5'd0, 32'hAC07_0020, 32'h0000_050C);
    step();
    chk("to.stall_w0", {31'd0, stall}, 32'd1);
    step();
    step();
    chk("to.stall_w2", {31'd0, stall}, 32'd1);
    step();
    chk("to.stall_w3", {31'd0, stall}, 32'd0);
    step();
    chk_mw("timeout", 32'h0000_0020, 32'd0, 5'd0, 32'hAC07_0020, 32'h0000_050C, 1'b0, 1'b1);
    chk("to.req", {31'd0, bus_if.bus_req}, 32'd0);

    // ack in the timeout cycle wins
    set_in(32'h0000_0030, 32'd0, 5'd8, 32'h8C08_0030, 32'h0000_0510);
    step();
    step();
    step();
    step();
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'hCAFE_F00D;
    step();
    bus_if.bus_ack = 1'b0;
    chk_mw("race", 32'h0000_0030, 32'hCAFE_F00D, 5'd8, 32'h8C08_0030, 32'h0000_0510, 1'b0, 1'b0);

    // Reset during WAIT, then a stray ack
    set_in(32'h0000_0040, 32'd0, 5'd9, 32'h8C09_0040, 32'h0000_0514);
    step();
    chk("rst.req_wait", {31'd0, bus_if.bus_req}, 32'd1);
    reset = 1'b0;
    step();
    chk_mw("rst_wait", 32'd0, 32'd0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("rst.req", {31'd0, bus_if.bus_req}, 32'd0);
    reset = 1'b1;
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'hFFFF_FFFF;
    set_in(32'd0, 32'd0, 5'd0, 32'd0, 32'd0);
    chk("stray.stall", {31'd0, stall}, 32'd0);
    step();
    chk_mw("stray", 32'd0, 32'd0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("stray.req", {31'd0, bus_if.bus_req}, 32'd0);

    // Ack in IDLE with a non-memory op is ignored
    set_in(32'h0000_0099, 32'd0, 5'd1, 32'h0000_0821, 32'h0000_0600);
    step();
    bus_if.bus_ack = 1'b0;
    chk_mw("idle_ack", 32'h0000_0099, 32'd0, 5'd1, 32'h0000_0821, 32'h0000_0600, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
